// File: rtl/proj_hit_scanner_pkg.sv
// Shared game constants, slot encoding and scanner state type for the projectile hit scanner.
// Overlap sums use CMP_W bits so that the sums cannot wrap at the right or bottom screen edge.
package proj_hit_scanner_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int CMP_W    = 11;

  typedef logic [1:0] slot_t;
  localparam slot_t SLOT_NONE  = 2'd0;
  localparam slot_t SLOT_FIRST = 2'd1;
  localparam slot_t SLOT_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CMP,
    ST_HIT,
    ST_NEXT_SLOT,
    ST_DONE
  } scan_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/proj_hit_scanner_rect_overlap.sv
// Combinational axis-aligned rectangle overlap test (a = small object, b = large object); zero latency, no flow control.
// Both origins are zero-extended to CMP_W bits before the size is added.
module rect_overlap
  import proj_hit_scanner_pkg::*;
#(
  parameter int XW    = X_W,
  parameter int YW    = Y_W,
  parameter int CW    = CMP_W,
  parameter int A_W   = 2,
  parameter int A_H   = 8,
  parameter int B_W   = 20,
  parameter int B_H   = 16
) (
  input  logic [XW-1:0] a_x,
  input  logic [YW-1:0] a_y,
  input  logic [XW-1:0] b_x,
  input  logic [YW-1:0] b_y,
  output logic          overlap
);

  logic [CW-1:0] ax, ay, bx, by;

  always_comb begin
    ax = CW'(a_x);
    ay = CW'(a_y);
    bx = CW'(b_x);
    by = CW'(b_y);
    overlap = (ax < bx + CW'(B_W)) &&
              (bx < ax + CW'(A_W)) &&
              (ay < by + CW'(B_H)) &&
              (by < ay + CW'(A_H));
  end

endmodule

// File: rtl/proj_hit_scanner.sv
// Scans three projectile slots against the enemy table, 2 cycles per pair, 1 cycle per slot change; start is ignored while busy.
// Optional SCAN_OVERRUN_CNT_EN builds a saturating count of start requests rejected while busy.
module proj_hit_scanner
  import proj_hit_scanner_pkg::*;
#(
  parameter  int NUM_ENEMIES = 16,
  parameter  int PROJ_W      = 2,
  parameter  int PROJ_H      = 8,
  parameter  int ENEMY_W     = 20,
  parameter  int ENEMY_H     = 16,
  localparam int IDXW        = $clog2(NUM_ENEMIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      proj_active,
  input  logic [X_W-1:0]  proj1X,
  input  logic [X_W-1:0]  proj2X,
  input  logic [X_W-1:0]  proj3X,
  input  logic [Y_W-1:0]  proj1Y,
  input  logic [Y_W-1:0]  proj2Y,
  input  logic [Y_W-1:0]  proj3Y,
  output logic [IDXW-1:0] enemy_idx,
  input  logic [X_W-1:0]  enemyX,
  input  logic [Y_W-1:0]  enemyY,
  input  logic            enemy_alive,
  output logic            busy,
  output logic            done,
  output logic            projHit,
  output logic [1:0]      collidedProj,
  output logic            kill_en,
  output logic [IDXW-1:0] kill_idx,
  output logic [7:0]      overrun_cnt
);

  scan_state_t     state_q, state_d;
  slot_t           slot_q, slot_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [2:0]      act_q, act_d;
  pos_t [2:0]      pos_q, pos_d;

  pos_t            cur_pos;
  logic            overlap;
  logic            idx_last;

  always_comb begin
    cur_pos = pos_q[0];
    case (slot_q)
      2'd2:    cur_pos = pos_q[1];
      2'd3:    cur_pos = pos_q[2];
      default: cur_pos = pos_q[0];
    endcase
  end

  rect_overlap #(
    .XW  (X_W),
    .YW  (Y_W),
    .CW  (CMP_W),
    .A_W (PROJ_W),
    .A_H (PROJ_H),
    .B_W (ENEMY_W),
    .B_H (ENEMY_H)
  ) u_overlap (
    .a_x     (cur_pos.x),
    .a_y     (cur_pos.y),
    .b_x     (enemyX),
    .b_y     (enemyY),
    .overlap (overlap)
  );

  assign idx_last = (idx_q == IDXW'(NUM_ENEMIES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= SLOT_NONE;
      idx_q   <= '0;
      act_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    act_d   = act_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          act_d      = proj_active;
          pos_d[0].x = proj1X;
          pos_d[0].y = proj1Y;
          pos_d[1].x = proj2X;
          pos_d[1].y = proj2Y;
          pos_d[2].x = proj3X;
          pos_d[2].y = proj3Y;
          slot_d     = SLOT_FIRST;
          idx_d      = '0;
          state_d    = proj_active[0] ? ST_FETCH : ST_NEXT_SLOT;
        end
      end
      ST_FETCH: state_d = ST_CMP;
      ST_CMP: begin
        if (overlap && enemy_alive) begin
          state_d = ST_HIT;
        end else if (idx_last) begin
          state_d = ST_NEXT_SLOT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HIT: state_d = ST_NEXT_SLOT;
      ST_NEXT_SLOT: begin
        if (slot_q == SLOT_LAST) begin
          state_d = ST_DONE;
        end else begin
          // act_q bit slot_q is the mask bit of the following slot
          slot_d  = slot_q + 2'd1;
          idx_d   = '0;
          state_d = act_q[slot_q] ? ST_FETCH : ST_NEXT_SLOT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses are masked by rst so an abort never leaks a hit or done
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE) && !rst;
    projHit      = (state_q == ST_HIT) && !rst;
    kill_en      = projHit;
    collidedProj = projHit ? slot_q : SLOT_NONE;
    kill_idx     = projHit ? idx_q : '0;
    enemy_idx    = idx_q;
  end

`ifdef SCAN_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (start && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_proj_hit_scanner.sv
// Directed bench: stimulus pushes expected hit/done events, a negedge monitor pops and compares them.
module tb_proj_hit_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] proj_active = '0;
  logic [9:0] proj1X = '0, proj2X = '0, proj3X = '0;
  logic [8:0] proj1Y = '0, proj2Y = '0, proj3Y = '0;
  logic [3:0] enemy_idx;
  logic [9:0] enemyX;
  logic [8:0] enemyY;
  logic       enemy_alive;
  logic       busy, done, projHit, kill_en;
  logic [1:0] collidedProj;
  logic [3:0] kill_idx;
  logic [7:0] overrun_cnt;

  logic [9:0] tbl_x [16];
  logic [8:0] tbl_y [16];
  logic       tbl_a [16];

  typedef struct {
    bit is_hit;
    int slot;
    int idx;
    int k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   scan_t = 0;

  proj_hit_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .proj_active  (proj_active),
    .proj1X       (proj1X),
    .proj2X       (proj2X),
    .proj3X       (proj3X),
    .proj1Y       (proj1Y),
    .proj2Y       (proj2Y),
    .proj3Y       (proj3Y),
    .enemy_idx    (enemy_idx),
    .enemyX       (enemyX),
    .enemyY       (enemyY),
    .enemy_alive  (enemy_alive),
    .busy         (busy),
    .done         (done),
    .projHit      (projHit),
    .collidedProj (collidedProj),
    .kill_en      (kill_en),
    .kill_idx     (kill_idx),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Enemy register file: data appears one cycle after the address
  always @(posedge clk) begin
    enemyX      <= tbl_x[enemy_idx];
    enemyY      <= tbl_y[enemy_idx];
    enemy_alive <= tbl_a[enemy_idx];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_hit(input int slot, input int idx, input int k);
    exp_t e;
    e.is_hit = 1'b1; e.slot = slot; e.idx = idx; e.k = k;
    sb.push_back(e);
  endtask

  task automatic push_done(input int k);
    exp_t e;
    e.is_hit = 1'b0; e.slot = 0; e.idx = 0; e.k = k;
    sb.push_back(e);
  endtask

  task automatic set_far();
    for (int i = 0; i < 16; i++) begin
      tbl_x[i] = 10'd600;
      tbl_y[i] = 9'd20;
      tbl_a[i] = 1'b1;
    end
  endtask

  task automatic start_scan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scan_t = cyc;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit seen_idle;
    seen_idle = 1'b0;
    for (int i = 0; i < maxc && !seen_idle; i++) begin
      @(negedge clk);
      if (!busy) seen_idle = 1'b1;
    end
    if (!seen_idle) chk({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: any pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (projHit || kill_en || done) begin
      k = cyc - scan_t + 1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: projHit=%0d kill_en=%0d done=%0d slot=%0d idx=%0d, none expected (cycle %0d)",
                 projHit, kill_en, done, collidedProj, kill_idx, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_hit) begin
          chk("hit_projHit", int'(projHit), 1);
          chk("hit_kill_en", int'(kill_en), 1);
          chk("hit_collidedProj", int'(collidedProj), e.slot);
          chk("hit_kill_idx", int'(kill_idx), e.idx);
        end else begin
          chk("done_pulse", int'(done), 1);
          chk("done_busy", int'(busy), 1);
          chk("done_no_hit", int'(projHit), 0);
        end
        if (e.k >= 0) chk("event_cycle", k, e.k);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_far();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_projHit", int'(projHit), 0);
    chk("rst_collidedProj", int'(collidedProj), 0);
    chk("rst_kill_en", int'(kill_en), 0);
    chk("rst_kill_idx", int'(kill_idx), 0);
    chk("rst_enemy_idx", int'(enemy_idx), 0);
    chk("rst_overrun_cnt", int'(overrun_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single hit on enemy 5; inputs moved after start must not matter
    set_far();
    tbl_x[5] = 10'd95; tbl_y[5] = 9'd195;
    proj_active = 3'b111;
    proj1X = 10'd100; proj1Y = 9'd200;
    proj2X = 10'd300; proj2Y = 9'd400;
    proj3X = 10'd500; proj3Y = 9'd100;
    push_hit(1, 5, 13);
    push_done(81);
    start_scan();
    proj2X = 10'd95;  proj2Y = 9'd195;
    proj3X = 10'd100; proj3Y = 9'd200;
    wait_idle("single", 200);
    chk("single_drained", sb.size(), 0);

    // Enemies 3 and 7 both overlap slot 2; inactive slot 1 overlaps 3 too
    set_far();
    tbl_x[3] = 10'd195; tbl_y[3] = 9'd95;
    tbl_x[7] = 10'd190; tbl_y[7] = 9'd100;
    proj_active = 3'b010;
    proj1X = 10'd195; proj1Y = 9'd95;
    proj2X = 10'd200; proj2Y = 9'd100;
    push_hit(2, 3, 10);
    push_done(13);
    start_scan();
    wait_idle("lowest", 200);
    chk("lowest_drained", sb.size(), 0);

    // Dead overlapping enemy, all slots active: full-length scan
    set_far();
    tbl_x[5] = 10'd95; tbl_y[5] = 9'd195; tbl_a[5] = 1'b0;
    proj_active = 3'b111;
    proj1X = 10'd100; proj1Y = 9'd200;
    proj2X = 10'd300; proj2Y = 9'd400;
    proj3X = 10'd500; proj3Y = 9'd100;
    push_done(100);
    start_scan();
    wait_idle("dead", 200);
    chk("dead_busy_drop_cycle", cyc - scan_t + 1, 101);
    chk("dead_drained", sb.size(), 0);

    // Screen corner hit, then an enemy at the origin must not match
    set_far();
    tbl_x[0] = 10'd630; tbl_y[0] = 9'd470;
    proj_active = 3'b100;
    proj3X = 10'd639; proj3Y = 9'd479;
    push_hit(3, 0, 5);
    push_done(7);
    start_scan();
    wait_idle("edge", 200);
    tbl_x[0] = 10'd0; tbl_y[0] = 9'd0;
    push_done(36);
    start_scan();
    wait_idle("origin", 200);
    chk("edge_drained", sb.size(), 0);

    // Nothing active
    proj_active = 3'b000;
    push_done(4);
    start_scan();
    wait_idle("idle", 50);
    chk("idle_drained", sb.size(), 0);

    // Reset in cycle 20 with a hit pending on enemy 12
    set_far();
    tbl_x[12] = 10'd95; tbl_y[12] = 9'd195;
    proj_active = 3'b001;
    proj1X = 10'd100; proj1Y = 9'd200;
    start_scan();
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", int'(busy), 0);
    repeat (30) @(posedge clk);
    chk("rst_abort_no_events", sb.size(), 0);
    push_hit(1, 12, 27);
    push_done(31);
    start_scan();
    wait_idle("after_rst", 200);
    chk("after_rst_drained", sb.size(), 0);

    // start held for 300 edges: exactly three scans, the rest rejected
    set_far();
    proj_active = 3'b111;
    push_done(-1);
    push_done(-1);
    push_done(-1);
    @(posedge clk); #1 start = 1'b1;
    repeat (300) @(posedge clk);
    #1 start = 1'b0;
    wait_idle("overrun", 200);
`ifdef SCAN_OVERRUN_CNT_EN
    chk("overrun_cnt_sat", int'(overrun_cnt), 255);
`else
    chk("overrun_cnt_off", int'(overrun_cnt), 0);
`endif
    repeat (3) @(posedge clk);
    chk("overrun_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
